// File: rtl/regfile_dump_reader.sv
// Debug readout engine for the 32x32 register file.
// On start it walks [first_idx..last_idx], reads each register through the
// gated read port and streams every word as 4 bytes, LSB first, on a
// valid/ready byte interface.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  output logic              rf_rd_en,
  output logic [IDX_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NUM_BYTES = DATA_W / 8;
  // One bit wider than the index so NUM_REGS itself is representable.
  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   cur_idx_reg, cur_idx_next;
  logic [IDX_W-1:0]   last_idx_reg, last_idx_next;
  logic [1:0]         byte_cnt_reg, byte_cnt_next;
  logic [DATA_W-1:0]  shift_reg, shift_next;
  logic [DATA_W-1:0]  shift_dn;
  logic               err_reg, err_next;
  logic               range_ok;
  logic               last_byte;
  logic               last_reg_sel;

  assign range_ok     = (first_idx <= last_idx) && ({1'b0, last_idx} < NUM_REGS_W);
  assign last_byte    = (byte_cnt_reg == 2'd3);
  assign last_reg_sel = (cur_idx_reg == last_idx_reg);

  // Shift-down-by-one-byte path: each lane takes the lane above it, top lane fills with 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      if (gi == NUM_BYTES - 1) begin : g_top
        assign shift_dn[gi*8 +: 8] = 8'h00;
      end else begin : g_mid
        assign shift_dn[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
      end
    end
  endgenerate

  // State and datapath registers; async reset abandons any dump in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cur_idx_reg  <= '0;
      last_idx_reg <= '0;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_idx_reg  <= cur_idx_next;
      last_idx_reg <= last_idx_next;
      byte_cnt_reg <= byte_cnt_next;
      shift_reg    <= shift_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic: range check on start, one-cycle read, byte handshakes, finish pulse.
  always_comb begin
    state_next    = state_reg;
    cur_idx_next  = cur_idx_reg;
    last_idx_next = last_idx_reg;
    byte_cnt_next = byte_cnt_reg;
    shift_next    = shift_reg;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (range_ok) begin
            cur_idx_next  = first_idx;
            last_idx_next = last_idx;
            state_next    = READ;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      READ: begin
        shift_next    = rf_rdata;
        byte_cnt_next = 2'd0;
        state_next    = SEND;
      end
      SEND: begin
        if (out_ready) begin
          shift_next    = shift_dn;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (last_byte) begin
            if (last_reg_sel) begin
              state_next = FIN;
            end else begin
              cur_idx_next = cur_idx_reg + 1'b1;
              state_next   = READ;
            end
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The read address simply follows the current index, so it holds between reads.
  assign rf_rd_en  = (state_reg == READ);
  assign rf_addr   = cur_idx_reg;
  assign out_valid = (state_reg == SEND);
  assign out_data  = out_valid ? shift_reg[7:0] : 8'h00;
  assign out_last  = out_valid && last_byte && last_reg_sel;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FIN);
  assign err       = err_reg;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a register-file model feeds the
// read port, expected bytes are queued when a dump is started and popped as
// the DUT hands them over.
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic        rf_rd_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] rf_mem [32];
  logic [8:0]  exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int last_cnt = 0;
  logic toggle_en = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic held_last = 1'b0;

  regfile_dump_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .rf_rd_en  (rf_rd_en),
    .rf_addr   (rf_addr),
    .rf_rdata  (rf_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Gated register file: returns 0 when read enable is low.
  assign rf_rdata = rf_rd_en ? rf_mem[rf_addr] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input logic last_word);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back({(last_word && b == 3), w[b*8 +: 8]});
    end
  endtask

  // Returns just after the edge that sampled start (inside cycle N+1).
  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk); #1;
    start = 1'b1; first_idx = f; last_idx = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k >= budget) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Ready driver: held high, or toggling each cycle when backpressure is wanted.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = toggle_en ? ~out_ready : 1'b1;
    end
  end

  // Monitor: scoreboard pops on each accepted byte, plus stall-stability and event counters.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && stall_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {24'd0, out_data}, {24'd0, held_data});
        check("hold_last", {31'd0, out_last}, {31'd0, held_last});
      end
      stall_prev = rst_n && out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      if (rf_rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (out_last) last_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("byte 0x%02h last=%0d (expected 0x%02h last=%0d)", out_data, out_last, e[7:0], e[8]);
          check("byte", {24'd0, out_data}, {24'd0, e[7:0]});
          check("last", {31'd0, out_last}, {31'd0, e[8]});
        end
      end
    end
  end

  initial begin
    int rd0, bt0, dn0, ls0;
    rst_n = 1'b0; start = 1'b0; first_idx = '0; last_idx = '0;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'h0;
    rf_mem[1] = 32'h1122_3344;
    rf_mem[2] = 32'h5566_7788;
    rf_mem[5] = 32'hDEAD_BEEF;

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_addr", {27'd0, rf_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_flags", {28'd0, rf_rd_en, done, err, out_last}, 32'd0);
    check("idle_rd_cnt", rd_cnt, 0);
    $display("reset/idle checked");

    // Single register x5 with exact cycle timing
    rd0 = rd_cnt;
    push_word(rf_mem[5], 1'b1);
    start_dump(5'd5, 5'd5);
    @(negedge clk);
    check("read_en", {31'd0, rf_rd_en}, 32'd1);
    check("read_addr", {27'd0, rf_addr}, 32'd5);
    check("read_novalid", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("single_valid", {31'd0, out_valid}, 32'd1);
      check("single_data", {24'd0, out_data}, {24'd0, 8'(32'hDEADBEEF >> (8*k))});
      check("single_last", {31'd0, out_last}, (k == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("single_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("single_done_pulse", {31'd0, done}, 32'd0);
    check("single_idle", {31'd0, busy}, 32'd0);
    check("single_rd_pulses", rd_cnt - rd0, 1);
    $display("single register dump checked");

    // Range 1..2 with toggling backpressure
    rd0 = rd_cnt; ls0 = last_cnt;
    toggle_en = 1'b1;
    push_word(rf_mem[1], 1'b0);
    push_word(rf_mem[2], 1'b1);
    start_dump(5'd1, 5'd2);
    wait_done(200);
    toggle_en = 1'b0;
    check("range_queue_empty", exp_q.size(), 0);
    check("range_rd_pulses", rd_cnt - rd0, 2);
    check("range_last_once", last_cnt - ls0, 1);
    $display("range with backpressure checked");

    // Invalid range
    rd0 = rd_cnt; bt0 = beat_cnt;
    start_dump(5'd7, 5'd3);
    @(negedge clk);
    check("inv_err", {31'd0, err}, 32'd1);
    check("inv_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("inv_err_pulse", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    check("inv_no_beats", beat_cnt - bt0, 0);
    check("inv_no_reads", rd_cnt - rd0, 0);
    $display("invalid range checked");

    // Start while busy is ignored
    rd0 = rd_cnt; dn0 = done_cnt;
    rf_mem[3] = 32'hA1B2_C3D4;
    rf_mem[4] = 32'h0F1E_2D3C;
    push_word(rf_mem[3], 1'b0);
    push_word(rf_mem[4], 1'b1);
    start_dump(5'd3, 5'd4);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; first_idx = 5'd0; last_idx = 5'd0;
    @(posedge clk); #1; start = 1'b0;
    wait_done(100);
    repeat (4) @(negedge clk);
    check("busy_start_queue", exp_q.size(), 0);
    check("busy_start_reads", rd_cnt - rd0, 2);
    check("busy_start_done", done_cnt - dn0, 1);
    check("busy_start_idle", {31'd0, busy}, 32'd0);
    $display("start while busy checked");

    // Boundary registers: x0 and the top index
    push_word(32'h0, 1'b1);
    start_dump(5'd0, 5'd0);
    wait_done(50);
    push_word(rf_mem[30], 1'b0);
    push_word(rf_mem[31], 1'b1);
    start_dump(5'd30, 5'd31);
    wait_done(50);
    @(negedge clk);
    check("boundary_queue", exp_q.size(), 0);
    $display("boundary registers checked");

    // Reset mid-dump after the second byte
    dn0 = done_cnt;
    push_word(rf_mem[5], 1'b1);
    bt0 = beat_cnt;
    start_dump(5'd5, 5'd5);
    for (int k = 0; k < 50 && beat_cnt < bt0 + 2; k++) begin
      @(negedge clk); #1;
    end
    check("mid_two_beats", beat_cnt - bt0, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_flags", {29'd0, rf_rd_en, done, out_last}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_no_done", done_cnt - dn0, 0);
    bt0 = beat_cnt;
    rf_mem[10] = 32'hCAFE_F00D;
    rf_mem[11] = 32'h1357_9BDF;
    push_word(rf_mem[10], 1'b0);
    push_word(rf_mem[11], 1'b1);
    start_dump(5'd10, 5'd11);
    wait_done(100);
    @(negedge clk);
    check("post_rst_beats", beat_cnt - bt0, 8);
    check("post_rst_queue", exp_q.size(), 0);
    $display("reset mid-dump checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
